mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one Wishbone-style memory port between instruction fetch (IF) and the data stage (DM).
//  DM requests are driven by MemRead/MemWrite/MemSize from the decoder.
//  Sequences each access: grant, byte-lane steering, sign-extension for lb, bus timeout and misalignment error.
//  Sits between the core pipeline and the single-ported instruction/data memory.
// PARAMETERS
//  TIMEOUT_CYCLES   16  bus cycles without bus_ack before the access is aborted with error (>=2)
//  FETCH_STARVE_MAX 2   consecutive DM grants allowed while if_req is pending; next grant goes to IF (>=1)
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  reset      in   1   synchronous, active-high
//  if_req     in   1   fetch request; held with if_addr stable until if_ack
//  if_addr    in   32  fetch address, word access always
//  if_rdata   out  32  fetch data, valid while if_ack=1
//  if_ack     out  1   one-cycle completion pulse
//  if_err     out  1   with if_ack: timeout or misaligned fetch
//  dm_req     in   1   data request (MemRead|MemWrite); held with dm_* inputs stable until dm_ack
//  dm_we      in   1   1 = store, 0 = load
//  dm_size    in   1   1 = 32-bit, 0 = 8-bit (MemSize encoding)
//  dm_addr    in   32  byte address
//  dm_wdata   in   32  store data; byte store uses [7:0]
//  dm_rdata   out  32  load data, lb sign-extended; valid while dm_ack=1
//  dm_ack     out  1   one-cycle completion pulse
//  dm_err     out  1   with dm_ack: timeout or misaligned word
//  bus_cyc    out  1   bus cycle active
//  bus_stb    out  1   strobe, equal to bus_cyc
//  bus_we     out  1   write enable
//  bus_adr    out  32  word-aligned address ({addr[31:2],2'b00})
//  bus_sel    out  4   byte lane enables
//  bus_dat_o  out  32  write data
//  bus_dat_i  in   32  read data, sampled when bus_ack=1
//  bus_ack    in   1   slave acknowledge
// BEHAVIOUR
//  Reset: state IDLE, all counters 0; every output 0 (bus_* registered, *_ack/*_err/*_rdata gated by state).
//  States:
//   IDLE -> DATA on legal dm grant.
//   IDLE -> FETCH on legal if grant.
//   IDLE -> DERR/IERR on misaligned grant.
//   DATA/FETCH -> IDLE on bus_ack or timeout.
//   DERR/IERR -> IDLE after one cycle.
//  Grant in IDLE:
//   dm_req wins unless if_req=1 and starve_cnt==FETCH_STARVE_MAX.
//   starve_cnt +1 per DM grant while if_req=1; cleared on IF grant or when if_req=0 at grant time.
//  Latency:
//   Request sampled in IDLE cycle N; bus_cyc/stb high from cycle N+1.
//   Request latched at grant; addr/size/we are frozen for the access.
//   *_ack/*_rdata are combinational in the bus_ack cycle (ack = state match & bus_ack); FSM returns to IDLE next edge.
//   Minimum access is 2 cycles.
//   A requester may present its next request the cycle after ack.
//  Lanes:
//   Word: bus_sel=4'hF, bus_dat_o=wdata, rdata=bus_dat_i.
//   Byte: bus_sel=1<<addr[1:0], bus_dat_o={4{wdata[7:0]}}, rdata=sext(bus_dat_i[8*addr[1:0]+:8]).
//   Store ack returns rdata=0.
//  Misaligned word (addr[1:0]!=0, including any if_addr):
//   No bus cycle.
//   State DERR/IERR in cycle N+1 pulses ack+err.
//  Timeout:
//   Counter clears on entering DATA/FETCH and counts each cycle without bus_ack.
//   When count reaches TIMEOUT_CYCLES-1 with no ack: ack+err pulse that cycle, bus_cyc drops next edge.
//   bus_ack in the same cycle wins (normal ack, no err).
//  Other conditions:
//   bus_ack while IDLE is ignored.
//   Reset mid-access: bus_cyc drops next edge, no ack is issued, counters clear.
//   The requester must retry.
// STRUCTURE
//  mem_arb_pkg:
//   arb_state_t {IDLE,DATA,FETCH,DERR,IERR}
//   MEM_SIZE_BYTE=1'b0, MEM_SIZE_WORD=1'b1
//   lane-select function
//  Sub-module mem_lane_fmt (combinational):
//   Inputs: size, addr[1:0], wdata, bus_dat_i.
//   Outputs: sel, dat_o, rdata.
//  FSM, grant logic and counters stay in mem_port_arbiter.
// TESTING
//  1. Reset asserted mid-DATA access -> next cycle bus_cyc=0, bus_sel=0, dm_ack=0; FSM in IDLE.
//  2. if_req, if_addr=0x1000; bus_ack 2 cycles after stb with 0xDEADBEEF -> bus_adr=0x1000, sel=F, we=0;
//     if_ack=1 with if_rdata=0xDEADBEEF in the ack cycle.
//  3. sb: dm_addr=0x2003, wdata=0x000000A5 -> bus_we=1, sel=4'b1000, bus_dat_o=0xA5A5A5A5, bus_adr=0x2000.
//  4. lb: dm_addr=0x2001, bus_dat_i=0x12348056 -> dm_rdata=0xFFFFFF80;
//     same access with bus_dat_i=0x12347F56 -> 0x0000007F.
//  5. if_req and dm_req both held high, zero-wait bus_ack, FETCH_STARVE_MAX=2 -> grant order D,D,F,D,D,F.
//  6. No bus_ack, TIMEOUT_CYCLES=16 -> dm_ack=dm_err=1 in 16th bus cycle, then bus_cyc=0.
//     lw at 0x2002 -> dm_ack=dm_err=1 at N+1, bus_cyc never asserted.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, size codes and byte-lane helper for the memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [2:0] {IDLE, DATA, FETCH, DERR, IERR} arb_state_t;

   localparam logic MEM_SIZE_BYTE = 1'b0;
   localparam logic MEM_SIZE_WORD = 1'b1;

   function automatic logic [3:0] lane_sel(input logic [1:0] lo);
      return 4'b0001 << lo;
   endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// mem_lane_fmt: byte-lane steering for stores and lane extraction with sign extension for loads.
import mem_arb_pkg::*;

module mem_lane_fmt (
   input  logic        size,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   input  logic [31:0] bus_dat_i,
   output logic [3:0]  sel,
   output logic [31:0] dat_o,
   output logic [31:0] rdata
);

   logic [7:0] rbyte;

   always_comb begin
      rbyte = bus_dat_i[8*addr +: 8];
      sel   = size == MEM_SIZE_WORD ? 4'hF : lane_sel(addr);
      dat_o = size == MEM_SIZE_WORD ? wdata : {4{wdata[7:0]}};
      rdata = size == MEM_SIZE_WORD ? bus_dat_i : {{24{rbyte[7]}}, rbyte};
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one Wishbone-style port between fetch and data stage, with
// fetch anti-starvation, byte lanes, misalignment errors and a bus timeout.
import mem_arb_pkg::*;

module mem_port_arbiter #(
   parameter int TIMEOUT_CYCLES   = 16,
   parameter int FETCH_STARVE_MAX = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   output logic        if_err,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic        dm_size,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_ack,
   output logic        dm_err,
   output logic        bus_cyc,
   output logic        bus_stb,
   output logic        bus_we,
   output logic [31:0] bus_adr,
   output logic [3:0]  bus_sel,
   output logic [31:0] bus_dat_o,
   input  logic [31:0] bus_dat_i,
   input  logic        bus_ack
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam int SW = $clog2(FETCH_STARVE_MAX + 1);

   arb_state_t  state, state_nx;
   logic        lat_we, lat_size;
   logic [1:0]  lat_lo;
   logic [TW-1:0] tcnt;
   logic [SW-1:0] starve;
   logic        gnt_d, gnt_i, dm_mis, if_mis, busy, tmo, done, go;
   logic        f_size;
   logic [1:0]  f_lo;
   logic [31:0] adr_n, f_dat_o, f_rdata;
   logic [3:0]  f_sel;

   mem_lane_fmt u_fmt (
      .size      (f_size),
      .addr      (f_lo),
      .wdata     (dm_wdata),
      .bus_dat_i (bus_dat_i),
      .sel       (f_sel),
      .dat_o     (f_dat_o),
      .rdata     (f_rdata)
   );

   // In IDLE the formatter sees the request being granted; during the access, the latched one.
   always_comb begin
      gnt_d  = state == IDLE && dm_req && !(if_req && starve == SW'(FETCH_STARVE_MAX));
      gnt_i  = state == IDLE && if_req && !gnt_d;
      dm_mis = dm_size == MEM_SIZE_WORD && dm_addr[1:0] != 2'b00;
      if_mis = if_addr[1:0] != 2'b00;
      busy   = state == DATA || state == FETCH;
      tmo    = busy && tcnt == TW'(TIMEOUT_CYCLES - 1);
      done   = busy && (bus_ack || tmo);
      adr_n  = gnt_d ? dm_addr : if_addr;
      f_size = state == IDLE ? (gnt_d ? dm_size : MEM_SIZE_WORD) : lat_size;
      f_lo   = state == IDLE ? adr_n[1:0] : lat_lo;
      state_nx = state;
      if (gnt_d)
         state_nx = dm_mis ? DERR : DATA;
      else if (gnt_i)
         state_nx = if_mis ? IERR : FETCH;
      else if (done || state == DERR || state == IERR)
         state_nx = IDLE;
      go       = (gnt_d || gnt_i) && (state_nx == DATA || state_nx == FETCH);
      bus_stb  = bus_cyc;
      dm_ack   = state == DERR || (state == DATA && done);
      dm_err   = state == DERR || (state == DATA && tmo && !bus_ack);
      dm_rdata = state == DATA && bus_ack && !lat_we ? f_rdata : '0;
      if_ack   = state == IERR || (state == FETCH && done);
      if_err   = state == IERR || (state == FETCH && tmo && !bus_ack);
      if_rdata = state == FETCH && bus_ack ? f_rdata : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         lat_we    <= 1'b0;
         lat_size  <= 1'b0;
         lat_lo    <= '0;
         tcnt      <= '0;
         starve    <= '0;
         bus_cyc   <= 1'b0;
         bus_we    <= 1'b0;
         bus_adr   <= '0;
         bus_sel   <= '0;
         bus_dat_o <= '0;
      end else begin
         state <= state_nx;
         tcnt  <= busy ? tcnt + 1'b1 : '0;
         if (gnt_d || gnt_i) begin
            lat_we    <= gnt_d && dm_we;
            lat_size  <= f_size;
            lat_lo    <= f_lo;
            starve    <= gnt_i || !if_req ? '0 : starve + 1'b1;
            bus_cyc   <= go;
            bus_we    <= go && gnt_d && dm_we;
            bus_adr   <= go ? {adr_n[31:2], 2'b00} : '0;
            bus_sel   <= go ? f_sel : '0;
            bus_dat_o <= go && gnt_d && dm_we ? f_dat_o : '0;
         end else if (done) begin
            bus_cyc   <= 1'b0;
            bus_we    <= 1'b0;
            bus_adr   <= '0;
            bus_sel   <= '0;
            bus_dat_o <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed tests of reset, fetch, byte/word data accesses, starvation, timeout, misalignment.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_ack, if_err;
   logic        dm_req = 1'b0, dm_we = 1'b0, dm_size = 1'b0;
   logic [31:0] dm_addr = '0, dm_wdata = '0;
   logic [31:0] dm_rdata;
   logic        dm_ack, dm_err;
   logic        bus_cyc, bus_stb, bus_we;
   logic [31:0] bus_adr, bus_dat_o;
   logic [3:0]  bus_sel;
   logic [31:0] bus_dat_i = '0;
   logic        bus_ack = 1'b0;
   int vectors = 0;
   int errors = 0;

   mem_port_arbiter #(.TIMEOUT_CYCLES(16), .FETCH_STARVE_MAX(2)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
      .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_err(dm_err),
      .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_adr(bus_adr), .bus_sel(bus_sel),
      .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i), .bus_ack(bus_ack)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic dm_set(input logic we, input logic size, input logic [31:0] addr, input logic [31:0] wdata);
      dm_req = 1'b1; dm_we = we; dm_size = size; dm_addr = addr; dm_wdata = wdata;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick; tick;
      vectors++;
      if ({bus_cyc, bus_stb, bus_we, bus_sel, bus_adr, dm_ack, if_ack, dm_err, if_err} !== '0) begin
         errors++; $display("FAIL reset_outputs: cyc=%b sel=%h adr=%h dm_ack=%b if_ack=%b, want all 0", bus_cyc, bus_sel, bus_adr, dm_ack, if_ack);
      end
      reset = 1'b0;
      dm_set(1'b0, 1'b1, 32'h2000, 32'h0);
      tick;
      vectors++;
      if (bus_cyc !== 1'b1) begin errors++; $display("FAIL reset_pre_access: cyc=%b want 1", bus_cyc); end
      reset = 1'b1;
      dm_req = 1'b0;
      tick;
      vectors++;
      if ({bus_cyc, bus_sel, dm_ack} !== 6'b0) begin
         errors++; $display("FAIL reset_mid_access: cyc=%b sel=%h dm_ack=%b want 0", bus_cyc, bus_sel, dm_ack);
      end
      reset = 1'b0;
      bus_ack = 1'b1;
      bus_dat_i = 32'h11111111;
      #1;
      vectors++;
      if ({dm_ack, if_ack, dm_rdata} !== 34'b0) begin
         errors++; $display("FAIL idle_ack_ignored: dm_ack=%b if_ack=%b rdata=%h want 0", dm_ack, if_ack, dm_rdata);
      end
      tick;
      bus_ack = 1'b0;
   endtask

   task automatic test_fetch;
      if_req = 1'b1;
      if_addr = 32'h1000;
      tick;
      vectors++;
      if ({bus_cyc, bus_stb, bus_we, bus_sel, bus_adr} !== {1'b1, 1'b1, 1'b0, 4'hF, 32'h1000}) begin
         errors++; $display("FAIL fetch_bus: cyc=%b stb=%b we=%b sel=%h adr=%h want 1 1 0 f 00001000", bus_cyc, bus_stb, bus_we, bus_sel, bus_adr);
      end
      tick;
      vectors++;
      if (if_ack !== 1'b0) begin errors++; $display("FAIL fetch_wait: if_ack=%b want 0", if_ack); end
      tick;
      bus_ack = 1'b1;
      bus_dat_i = 32'hDEADBEEF;
      #1;
      vectors++;
      if ({if_ack, if_err, if_rdata, dm_ack} !== {1'b1, 1'b0, 32'hDEADBEEF, 1'b0}) begin
         errors++; $display("FAIL fetch_ack: ack=%b err=%b rdata=%h want 1 0 deadbeef", if_ack, if_err, if_rdata);
      end
      if_req = 1'b0;
      tick;
      bus_ack = 1'b0;
      vectors++;
      if ({bus_cyc, if_ack} !== 2'b00) begin errors++; $display("FAIL fetch_end: cyc=%b ack=%b want 0 0", bus_cyc, if_ack); end
   endtask

   task automatic test_byte_store;
      dm_set(1'b1, 1'b0, 32'h2003, 32'h000000A5);
      tick;
      vectors++;
      if ({bus_we, bus_sel, bus_dat_o, bus_adr} !== {1'b1, 4'b1000, 32'hA5A5A5A5, 32'h2000}) begin
         errors++; $display("FAIL sb_bus: we=%b sel=%b dat=%h adr=%h want 1 1000 a5a5a5a5 00002000", bus_we, bus_sel, bus_dat_o, bus_adr);
      end
      bus_ack = 1'b1;
      bus_dat_i = 32'hFFFFFFFF;
      #1;
      vectors++;
      if ({dm_ack, dm_err, dm_rdata} !== {1'b1, 1'b0, 32'h0}) begin
         errors++; $display("FAIL sb_ack: ack=%b err=%b rdata=%h want 1 0 00000000", dm_ack, dm_err, dm_rdata);
      end
      dm_req = 1'b0;
      tick;
      bus_ack = 1'b0;
   endtask

   task automatic test_loads;
      dm_set(1'b0, 1'b0, 32'h2001, 32'h0);
      tick;
      vectors++;
      if ({bus_we, bus_sel, bus_adr} !== {1'b0, 4'b0010, 32'h2000}) begin
         errors++; $display("FAIL lb_bus: we=%b sel=%b adr=%h want 0 0010 00002000", bus_we, bus_sel, bus_adr);
      end
      bus_ack = 1'b1;
      bus_dat_i = 32'h12348056;
      #1;
      vectors++;
      if (dm_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_neg: rdata=%h want ffffff80", dm_rdata); end
      bus_dat_i = 32'h12347F56;
      #1;
      vectors++;
      if (dm_rdata !== 32'h0000007F) begin errors++; $display("FAIL lb_pos: rdata=%h want 0000007f", dm_rdata); end
      dm_req = 1'b0;
      tick;
      bus_ack = 1'b0;
      dm_set(1'b0, 1'b1, 32'h2004, 32'h0);
      tick;
      bus_ack = 1'b1;
      bus_dat_i = 32'hCAFE0123;
      #1;
      vectors++;
      if ({bus_sel, bus_adr, dm_rdata} !== {4'hF, 32'h2004, 32'hCAFE0123}) begin
         errors++; $display("FAIL lw: sel=%h adr=%h rdata=%h want f 00002004 cafe0123", bus_sel, bus_adr, dm_rdata);
      end
      dm_set(1'b1, 1'b1, 32'h2008, 32'h87654321);
      tick;
      bus_ack = 1'b0;
      tick;
      vectors++;
      if ({bus_we, bus_sel, bus_dat_o} !== {1'b1, 4'hF, 32'h87654321}) begin
         errors++; $display("FAIL sw_bus: we=%b sel=%h dat=%h want 1 f 87654321", bus_we, bus_sel, bus_dat_o);
      end
      bus_ack = 1'b1;
      dm_req = 1'b0;
      tick;
      bus_ack = 1'b0;
   endtask

   task automatic test_starvation;
      logic [7:0] got [6];
      logic [7:0] want [6];
      int n = 0;
      want = '{"D", "D", "F", "D", "D", "F"};
      dm_set(1'b0, 1'b1, 32'h3000, 32'h0);
      if_req = 1'b1;
      if_addr = 32'h1000;
      for (int i = 0; i < 12; i++) begin
         tick;
         bus_ack = bus_cyc;
         #1;
         if (n < 6 && dm_ack) begin got[n] = "D"; n++; end
         else if (n < 6 && if_ack) begin got[n] = "F"; n++; end
      end
      dm_req = 1'b0;
      if_req = 1'b0;
      tick;
      bus_ack = 1'b0;
      vectors++;
      if (n != 6) begin errors++; $display("FAIL starve_count: grants=%0d want 6", n); end
      for (int i = 0; i < n; i++) begin
         vectors++;
         if (got[i] !== want[i]) begin errors++; $display("FAIL starve_order[%0d]: got %s want %s", i, got[i], want[i]); end
      end
   endtask

   task automatic test_timeout;
      int early = 0;
      dm_set(1'b0, 1'b1, 32'h2000, 32'h0);
      tick;
      for (int i = 1; i < 16; i++) begin
         if (dm_ack !== 1'b0 || bus_cyc !== 1'b1) early++;
         tick;
      end
      vectors++;
      if (early != 0) begin errors++; $display("FAIL timeout_early: %0d bad cycles before 16th, want 0", early); end
      vectors++;
      if ({dm_ack, dm_err, bus_cyc} !== 3'b111) begin
         errors++; $display("FAIL timeout_pulse: ack=%b err=%b cyc=%b want 1 1 1", dm_ack, dm_err, bus_cyc);
      end
      dm_req = 1'b0;
      tick;
      vectors++;
      if ({bus_cyc, dm_ack} !== 2'b00) begin errors++; $display("FAIL timeout_end: cyc=%b ack=%b want 0 0", bus_cyc, dm_ack); end
      dm_set(1'b0, 1'b1, 32'h2000, 32'h0);
      for (int i = 0; i < 16; i++) tick;
      bus_ack = 1'b1;
      bus_dat_i = 32'h0BADF00D;
      #1;
      vectors++;
      if ({dm_ack, dm_err, dm_rdata} !== {1'b1, 1'b0, 32'h0BADF00D}) begin
         errors++; $display("FAIL timeout_ack_wins: ack=%b err=%b rdata=%h want 1 0 0badf00d", dm_ack, dm_err, dm_rdata);
      end
      dm_req = 1'b0;
      tick;
      bus_ack = 1'b0;
   endtask

   task automatic test_misaligned;
      dm_set(1'b0, 1'b1, 32'h2002, 32'h0);
      tick;
      vectors++;
      if ({dm_ack, dm_err, bus_cyc} !== 3'b110) begin
         errors++; $display("FAIL lw_misaligned: ack=%b err=%b cyc=%b want 1 1 0", dm_ack, dm_err, bus_cyc);
      end
      dm_req = 1'b0;
      tick;
      vectors++;
      if ({dm_ack, bus_cyc} !== 2'b00) begin errors++; $display("FAIL lw_misaligned_end: ack=%b cyc=%b want 0 0", dm_ack, bus_cyc); end
      if_req = 1'b1;
      if_addr = 32'h1002;
      tick;
      vectors++;
      if ({if_ack, if_err, bus_cyc, if_rdata} !== {3'b110, 32'h0}) begin
         errors++; $display("FAIL if_misaligned: ack=%b err=%b cyc=%b rdata=%h want 1 1 0 0", if_ack, if_err, bus_cyc, if_rdata);
      end
      if_req = 1'b0;
      tick;
   endtask

   initial begin
      test_reset;
      test_fetch;
      test_byte_store;
      test_loads;
      test_starvation;
      test_timeout;
      test_misaligned;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
